// File: rtl/cache_config.sv
// Shared cache/memory configuration for the cache hierarchy.
// Sizes, derived widths and the backing-memory FSM states.
package cache_config;

  localparam int DATA_SIZE       = 32;
  localparam int ADDR_SIZE       = 32;
  localparam int BLOCK_SIZE      = 16;
  localparam int MEMEORY_SIZE    = 2**20;
  localparam int BEATS_PER_BLOCK = BLOCK_SIZE / 4;
  localparam int MEM_IDX_BITS    = $clog2(MEMEORY_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_WAIT,
    WR_ACK
  } mem_state_e;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM behind the memory responder.
// One write port, registered read; contents survive reset.
module mem_word_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // write on demand, read every cycle from the same address
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder at the bottom of the cache hierarchy.
// Serves one block fill or write-back at a time after a fixed latency.
module cache_mem_responder
  import cache_config::*;
#(
  parameter int DATA_W    = DATA_SIZE,
  parameter int ADDR_W    = ADDR_SIZE,
  parameter int BEATS     = BEATS_PER_BLOCK,
  parameter int MEM_WORDS = MEMEORY_SIZE,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rlast,
  output logic              wack
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int BB    = $clog2(BEATS);

  localparam logic [3:0]    LAT_LOAD  = 4'(LATENCY - 1);
  localparam logic [BB-1:0] LAST_BEAT = BB'(BEATS - 1);

  mem_state_e r_state;
  mem_state_e w_next;

  logic [IDX_W-BB-1:0] r_base;
  logic [BB-1:0]       r_beat;
  logic [3:0]          r_lat;

  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_addr;
  logic [BB-1:0]     w_off;
  logic [DATA_W-1:0] w_q;
  logic              w_req_hs;
  logic              w_wbeat;
  logic              w_we;
  logic              w_lat_zero;
  logic              w_last;
  logic              w_unused_addr;

  assign w_req_idx  = req_addr[2 +: IDX_W];
  assign w_req_hs   = req_valid && (r_state == IDLE);
  assign w_wbeat    = wvalid && (r_state == WR_BURST);
  assign w_lat_zero = (r_lat == 4'd0);
  assign w_last     = (r_beat == LAST_BEAT);

  // upper bits wrap, byte and in-block offsets are dropped
  assign w_unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2],
                           req_addr[1:0],
                           w_req_idx[BB-1:0]};

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and handshake outputs
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    wack      = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = req_write ? WR_BURST : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (w_lat_zero) begin
          w_next = RD_BURST;
        end
      end
      RD_BURST: begin
        rvalid = 1'b1;
        rlast  = w_last;
        if (w_last) begin
          w_next = IDLE;
        end
      end
      WR_BURST: begin
        wready = 1'b1;
        if (wvalid && w_last) begin
          w_next = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (w_lat_zero) begin
          w_next = WR_ACK;
        end
      end
      WR_ACK: begin
        wack   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // block base, beat and latency counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base <= '0;
      r_beat <= '0;
      r_lat  <= 4'd0;
    end else begin
      if (w_req_hs) begin
        r_base <= w_req_idx[IDX_W-1:BB];
        r_beat <= '0;
        r_lat  <= LAT_LOAD;
      end
      if ((r_state == RD_WAIT || r_state == WR_WAIT)
          && !w_lat_zero) begin
        r_lat <= r_lat - 4'd1;
      end
      if (r_state == RD_BURST || w_wbeat) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_wbeat && w_last) begin
        r_lat <= LAT_LOAD;
      end
    end
  end

  // read address runs one beat ahead so rdata lines up with rvalid
  always_comb begin
    w_off = '0;
    unique case (r_state)
      WR_BURST: w_off = r_beat;
      RD_BURST: w_off = BB'(r_beat + 1'b1);
      default:  w_off = '0;
    endcase
  end

  assign w_addr = {r_base, w_off};
  assign w_we   = w_wbeat && !rst;
  assign rdata  = rvalid ? w_q : '0;

  mem_word_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_WORDS),
    .AW     (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (wdata),
    .o_rdata (w_q)
  );

endmodule
